fetch_prefetch_stage: RTL and testbench

- Parametrised successor of the basic fetch stage. Adds a PC generator with a decoupled instruction-memory request/response handshake and multiple outstanding requests.
- Adds branch/jump redirect with squashing of in-flight responses, and a prefetch FIFO feeding decode through a valid/ready interface.
- Sits between instruction memory and the decode stage.

---
 rtl/fetch_prefetch_stage.sv | 202 ++++++++++++++++++++
 tb/tb_fetch_prefetch_stage.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_stage.sv
// fetch_prefetch_stage: PC generator with decoupled imem req/rsp, redirect squash and prefetch FIFO to decode.
// Latency: with zero-wait memory, first instruction reaches if_valid 2 cycles after reset release; 1 instr/cycle after that.
// Backpressure: if_ready low fills the FIFO; requests stop once FIFO occupancy plus live in-flight requests reach FIFO_DEPTH.
//
// Ports:
//   clk, reset                      - clock and asynchronous active-high reset
//   imem_req_valid/ready/addr       - instruction-memory request; valid may be withdrawn only by a redirect
//   imem_rsp_valid/data             - in-order instruction words, no backpressure
//   redirect_valid/redirect_pc      - control-flow redirect; flushes FIFO and squashes in-flight responses
//   if_valid/ready/pc/instr         - FIFO head towards decode

// Generic synchronous FIFO with flush. Push while full is legal only together
// with a pop; the write then lands in the slot being vacated by the head.
// Latency: pushed entry is visible at the head on the following cycle.
// Backpressure: none internally; the producer must respect o_count.
module fetch_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_flush,
    input  logic                   i_push_vld,
    input  logic [W-1:0]           i_push_dat,
    input  logic                   i_pop,
    output logic [$clog2(DEPTH):0] o_count,
    output logic [W-1:0]           o_head_dat
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_pop;

    assign w_pop      = i_pop && (r_count != '0);
    assign o_count    = r_count;
    assign o_head_dat = r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            // Storage is cleared so the head reads zero while reset is high.
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            // Flush wins over any coincident push or pop.
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push_vld) begin
                r_mem[r_wr_ptr] <= i_push_dat;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (i_push_vld && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!i_push_vld && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end
endmodule

module fetch_prefetch_stage #(
    parameter int              XLEN            = 32,
    parameter logic [XLEN-1:0] RESET_PC        = '0,
    parameter int              FIFO_DEPTH      = 4,
    parameter int              MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_instr
);
    // Outstanding counter holds 0..MAX_OUTSTANDING; drop counter never exceeds it.
    localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
    // FIFO occupancy counter holds 0..FIFO_DEPTH.
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;
    // Credit sum can reach FIFO_DEPTH + MAX_OUTSTANDING before subtraction.
    localparam int CW  = $clog2(FIFO_DEPTH + MAX_OUTSTANDING + 1);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } fq_ent_t;

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_rsp_pc;
    logic [OW-1:0]   r_outstanding;
    logic [OW-1:0]   r_drop_cnt;

    logic [FCW-1:0]  w_fifo_count;
    fq_ent_t         w_push_ent;
    fq_ent_t         w_head_ent;
    logic [CW-1:0]   w_inflight;
    logic [XLEN-1:0] w_redirect_pc;
    logic            w_out_ok;
    logic            w_credit_ok;
    logic            w_req_vld;
    logic            w_req_fire;
    logic            w_rsp_acc;
    logic            w_rsp_drop;
    logic            w_push;
    logic            w_pop;

    assign w_redirect_pc = redirect_pc & ALIGN_MASK;

    // Requests that will still land in the FIFO (squashed ones excluded) plus
    // current occupancy must stay below depth, so a push always has a slot.
    assign w_inflight  = CW'(w_fifo_count) + CW'(r_outstanding) - CW'(r_drop_cnt);
    assign w_credit_ok = w_inflight < CW'(FIFO_DEPTH);
    assign w_out_ok    = r_outstanding < OW'(MAX_OUTSTANDING);

    // A redirect withdraws the request in the same cycle: the old fetch_pc is stale.
    assign w_req_vld  = !reset && !redirect_valid && w_out_ok && w_credit_ok;
    assign w_req_fire = w_req_vld && imem_req_ready;

    // A response with nothing outstanding is a protocol violation and is ignored.
    assign w_rsp_acc  = imem_rsp_valid && (r_outstanding != '0);
    assign w_rsp_drop = w_rsp_acc && (r_drop_cnt != '0);
    // On a redirect cycle the live response belongs to the old stream too.
    assign w_push     = w_rsp_acc && !w_rsp_drop && !redirect_valid;

    assign if_valid = !reset && (w_fifo_count != '0);
    assign w_pop    = if_valid && if_ready;

    assign w_push_ent.pc    = r_rsp_pc;
    assign w_push_ent.instr = imem_rsp_data;

    assign imem_req_valid = w_req_vld;
    assign imem_req_addr  = r_fetch_pc & ALIGN_MASK;
    assign if_pc          = w_head_ent.pc;
    assign if_instr       = w_head_ent.instr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            // Fire and response together leave the count unchanged.
            if (w_req_fire && !w_rsp_acc) begin
                r_outstanding <= r_outstanding + 1'b1;
            end else if (!w_req_fire && w_rsp_acc) begin
                r_outstanding <= r_outstanding - 1'b1;
            end

            if (redirect_valid) begin
                r_fetch_pc <= w_redirect_pc;
                r_rsp_pc   <= w_redirect_pc;
                // Every request still in flight after this cycle is stale,
                // whatever the previous drop count was.
                r_drop_cnt <= r_outstanding - OW'(w_rsp_acc);
            end else begin
                if (w_req_fire) begin
                    r_fetch_pc <= r_fetch_pc + PC_STEP;
                end
                if (w_push) begin
                    r_rsp_pc <= r_rsp_pc + PC_STEP;
                end
                if (w_rsp_drop) begin
                    r_drop_cnt <= r_drop_cnt - 1'b1;
                end
            end
        end
    end

    fetch_fifo #(
        .W     (XLEN + 32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (reset),
        .i_flush    (redirect_valid),
        .i_push_vld (w_push),
        .i_push_dat (w_push_ent),
        .i_pop      (w_pop),
        .o_count    (w_fifo_count),
        .o_head_dat (w_head_ent)
    );
endmodule

// File: tb/tb_fetch_prefetch_stage.sv
module tb_fetch_prefetch_stage;
    localparam logic [31:0] K = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    fetch_prefetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    mreq_t mq[$];
    exp_t  sb[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int mem_lat = 1;
    int tb_out = 0;
    int tb_out_max = 0;
    int n_fire = 0;

    logic        s_req_vld;
    logic [31:0] s_req_addr;
    logic        s_if_vld;
    logic [31:0] s_if_pc;
    logic [31:0] s_if_instr;
    logic        s_pop;
    int          s_cyc;

    // One clock cycle: sample mid-cycle, model the memory, advance past the edge.
    task automatic tick();
        mreq_t m;
        #3;
        s_req_vld  = imem_req_valid;
        s_req_addr = imem_req_addr;
        s_if_vld   = if_valid;
        s_if_pc    = if_pc;
        s_if_instr = if_instr;
        s_pop      = if_valid && if_ready && !redirect_valid && !reset;
        s_cyc      = cyc;
        if (imem_req_valid && imem_req_ready && !reset) begin
            m.addr = imem_req_addr;
            m.due  = cyc + mem_lat;
            mq.push_back(m);
            tb_out++;
            n_fire++;
            if (tb_out > tb_out_max) tb_out_max = tb_out;
        end
        @(posedge clk);
        #2;
        cyc++;
        if (mq.size() > 0 && mq[0].due == cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mq[0].addr ^ K;
            void'(mq.pop_front());
            tb_out--;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    endtask

    task automatic push_exp(input logic [31:0] pc0, input int n);
        exp_t e;
        logic [31:0] pc;
        pc = pc0;
        for (int i = 0; i < n; i++) begin
            e.pc    = pc;
            e.instr = pc ^ K;
            sb.push_back(e);
            pc = pc + 32'd4;
        end
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        mq.delete();
        sb.delete();
        tb_out     = 0;
        tb_out_max = 0;
        n_fire     = 0;
        repeat (3) tick();
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        imem_req_ready = 1'b1;
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        mem_lat        = 1;
        repeat (3) tick();
        n_cmp++;
        if (s_req_vld !== 1'b0 || s_if_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_valids req_valid=%b if_valid=%b required 0/0", s_req_vld, s_if_vld);
        end
        n_cmp++;
        if (s_if_pc !== 32'h0 || s_if_instr !== 32'h0 || s_req_addr !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_data if_pc=%h if_instr=%h addr=%h required 0", s_if_pc, s_if_instr, s_req_addr);
        end
        reset = 1'b0;
        cyc   = 0;
        tick();
        n_cmp++;
        if (s_req_vld !== 1'b1 || s_req_addr !== 32'h0 || s_if_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_cycle0 req_valid=%b addr=%h if_valid=%b required 1/00000000/0",
                     s_req_vld, s_req_addr, s_if_vld);
        end
        tick();
        n_cmp++;
        if (s_if_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_cycle1 if_valid=%b required 0", s_if_vld);
        end
        tick();
        n_cmp++;
        if (s_if_vld !== 1'b1 || s_if_pc !== 32'h0 || s_if_instr !== K) begin
            n_bad++;
            $display("FAIL reset_cycle2 if_valid=%b pc=%h instr=%h required 1/00000000/%h",
                     s_if_vld, s_if_pc, s_if_instr, K);
        end
    endtask

    task automatic test_stream();
        exp_t e;
        int first_pop = -1;
        int last_pop  = -1;
        do_reset();
        mem_lat        = 1;
        imem_req_ready = 1'b1;
        if_ready       = 1'b1;
        push_exp(32'h0, 20);
        for (int i = 0; i < 60 && sb.size() > 0; i++) begin
            tick();
            if (s_pop) begin
                if (first_pop < 0) first_pop = s_cyc;
                last_pop = s_cyc;
                e = sb.pop_front();
                n_cmp++;
                if (s_if_pc !== e.pc || s_if_instr !== e.instr) begin
                    n_bad++;
                    $display("FAIL stream_data pc=%h instr=%h required %h/%h", s_if_pc, s_if_instr, e.pc, e.instr);
                end
            end
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL stream_timeout remaining=%0d required 0", sb.size());
        end
        n_cmp++;
        if (first_pop != 2 || last_pop - first_pop != 19) begin
            n_bad++;
            $display("FAIL stream_rate first=%0d span=%0d required 2/19", first_pop, last_pop - first_pop);
        end
        n_cmp++;
        if (tb_out_max > 2) begin
            n_bad++;
            $display("FAIL stream_outstanding max=%0d required <=2", tb_out_max);
        end
    endtask

    task automatic test_stall();
        exp_t e;
        do_reset();
        mem_lat        = 1;
        imem_req_ready = 1'b1;
        if_ready       = 1'b0;
        repeat (10) tick();
        n_cmp++;
        if (n_fire != 4 || s_req_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_credit fires=%0d req_valid=%b required 4/0", n_fire, s_req_vld);
        end
        n_cmp++;
        if (s_if_vld !== 1'b1 || s_if_pc !== 32'h0) begin
            n_bad++;
            $display("FAIL stall_head if_valid=%b pc=%h required 1/00000000", s_if_vld, s_if_pc);
        end
        push_exp(32'h0, 5);
        if_ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() > 0; i++) begin
            tick();
            if (s_pop) begin
                e = sb.pop_front();
                n_cmp++;
                if (s_if_pc !== e.pc || s_if_instr !== e.instr) begin
                    n_bad++;
                    $display("FAIL stall_drain pc=%h instr=%h required %h/%h", s_if_pc, s_if_instr, e.pc, e.instr);
                end
            end
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL stall_timeout remaining=%0d required 0", sb.size());
        end
    endtask

    task automatic test_redirect();
        exp_t e;
        do_reset();
        mem_lat        = 3;
        imem_req_ready = 1'b1;
        if_ready       = 1'b1;
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        tick();
        n_cmp++;
        if (s_if_vld !== 1'b0 || s_req_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL redirect_after if_valid=%b req_valid=%b required 0/0", s_if_vld, s_req_vld);
        end
        push_exp(32'h100, 4);
        for (int i = 0; i < 40 && sb.size() > 0; i++) begin
            tick();
            if (s_pop) begin
                e = sb.pop_front();
                n_cmp++;
                if (s_if_pc !== e.pc || s_if_instr !== e.instr) begin
                    n_bad++;
                    $display("FAIL redirect_data pc=%h instr=%h required %h/%h", s_if_pc, s_if_instr, e.pc, e.instr);
                end
            end
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL redirect_timeout remaining=%0d required 0", sb.size());
        end
    endtask

    task automatic test_redirect_coincident();
        exp_t e;
        do_reset();
        mem_lat        = 1;
        imem_req_ready = 1'b1;
        if_ready       = 1'b1;
        push_exp(32'h0, 3);
        repeat (5) begin
            tick();
            if (s_pop) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL coinc_extra pc=%h required no pop", s_if_pc);
                end else begin
                    e = sb.pop_front();
                    if (s_if_pc !== e.pc || s_if_instr !== e.instr) begin
                        n_bad++;
                        $display("FAIL coinc_pre pc=%h instr=%h required %h/%h", s_if_pc, s_if_instr, e.pc, e.instr);
                    end
                end
            end
        end
        // Redirect while a response arrives and the head is being popped.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        tick();
        n_cmp++;
        if (s_if_vld !== 1'b1 || s_req_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL coinc_cycle if_valid=%b req_valid=%b required 1/0", s_if_vld, s_req_vld);
        end
        redirect_valid = 1'b0;
        tick();
        n_cmp++;
        if (s_req_vld !== 1'b1 || s_req_addr !== 32'hFFFF_FFFC || s_if_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL coinc_target req_valid=%b addr=%h if_valid=%b required 1/fffffffc/0",
                     s_req_vld, s_req_addr, s_if_vld);
        end
        tick();
        n_cmp++;
        if (s_req_addr !== 32'h0) begin
            n_bad++;
            $display("FAIL coinc_wrap addr=%h required 00000000", s_req_addr);
        end
        push_exp(32'hFFFF_FFFC, 3);
        for (int i = 0; i < 20 && sb.size() > 0; i++) begin
            tick();
            if (s_pop) begin
                e = sb.pop_front();
                n_cmp++;
                if (s_if_pc !== e.pc || s_if_instr !== e.instr) begin
                    n_bad++;
                    $display("FAIL coinc_data pc=%h instr=%h required %h/%h", s_if_pc, s_if_instr, e.pc, e.instr);
                end
            end
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL coinc_timeout remaining=%0d required 0", sb.size());
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        do_reset();
        mem_lat        = 3;
        imem_req_ready = 1'b1;
        if_ready       = 1'b0;
        // Five cycles in: two entries buffered, one request outstanding, another pending.
        repeat (5) tick();
        #1;
        n_cmp++;
        if (if_valid !== 1'b1 || imem_req_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL areset_pre if_valid=%b req_valid=%b required 1/1", if_valid, imem_req_valid);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (if_valid !== 1'b0 || imem_req_valid !== 1'b0 || if_pc !== 32'h0) begin
            n_bad++;
            $display("FAIL areset_immediate if_valid=%b req_valid=%b if_pc=%h required 0/0/0",
                     if_valid, imem_req_valid, if_pc);
        end
        mq.delete();
        tb_out         = 0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        @(posedge clk);
        #2;
        tick();
        reset    = 1'b0;
        cyc      = 0;
        mem_lat  = 1;
        if_ready = 1'b1;
        push_exp(32'h0, 3);
        tick();
        n_cmp++;
        if (s_req_vld !== 1'b1 || s_req_addr !== 32'h0) begin
            n_bad++;
            $display("FAIL areset_restart req_valid=%b addr=%h required 1/00000000", s_req_vld, s_req_addr);
        end
        for (int i = 0; i < 20 && sb.size() > 0; i++) begin
            tick();
            if (s_pop) begin
                e = sb.pop_front();
                n_cmp++;
                if (s_if_pc !== e.pc || s_if_instr !== e.instr) begin
                    n_bad++;
                    $display("FAIL areset_data pc=%h instr=%h required %h/%h", s_if_pc, s_if_instr, e.pc, e.instr);
                end
            end
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL areset_timeout remaining=%0d required 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_coincident();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
